pulse_divider: RTL and testbench

Parametrised event divider for game timing (e.g. 1 kHz tick -> 1 Hz seconds tick).
- Counts qualified input events and emits a one-cycle output pulse on every DIV-th event.
- Divisor is programmable at run time.
- Supports continuous and one-shot operation, level or rising-edge input qualification, and keeps a wrapping total of emitted pulses.

---
 rtl/pulse_divider_pkg.sv | 17 +
 rtl/pulse_divider_if.sv | 32 +++
 rtl/pulse_divider_evt_qualify.sv | 28 ++
 rtl/pulse_divider.sv | 82 ++++++++
 tb/tb_pulse_divider.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_divider_pkg.sv
// Shared definitions for the pulse divider: default widths, divisor and
// input qualification encodings.
package pulse_divider_pkg;

    localparam int CNT_W_DEF       = 8;
    localparam int TOT_W_DEF       = 16;
    localparam int DIV_DEFAULT_DEF = 10;

    localparam int EVT_LEVEL = 0;
    localparam int EVT_RISE  = 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } run_state_e;

endpackage

// File: rtl/pulse_divider_if.sv
// Control and status bundle of the pulse divider; master drives the
// controls, slave is the divider itself.
interface pulse_divider_if
    import pulse_divider_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TOT_W = TOT_W_DEF
);

    logic             in_evt;
    logic             clear;
    logic             div_load;
    logic [CNT_W-1:0] div_value;
    logic             oneshot;
    logic             arm;
    logic             out_pulse;
    logic             done;
    logic [CNT_W-1:0] count;
    logic [TOT_W-1:0] total;
    logic             cfg_err;

    modport master (
        output in_evt, clear, div_load, div_value, oneshot, arm,
        input  out_pulse, done, count, total, cfg_err
    );

    modport slave (
        input  in_evt, clear, div_load, div_value, oneshot, arm,
        output out_pulse, done, count, total, cfg_err
    );

endinterface

// File: rtl/pulse_divider_evt_qualify.sv
// Turns a synchronous input into a per-cycle event strobe, either as a level
// or as a rising edge; also usable for debounced button inputs.
module pulse_divider_evt_qualify
    import pulse_divider_pkg::*;
#(
    parameter int EDGE_MODE = EVT_LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic in_evt,
    output logic ev
);

    logic prev;

    // History tracks the input every cycle, so a level held across a
    // clear or reload never looks like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= in_evt;
        end
    end

    assign ev = (EDGE_MODE == EVT_RISE) ? (in_evt & ~prev) : in_evt;

endmodule

// File: rtl/pulse_divider.sv
// Programmable event divider: one registered output pulse on every DIV-th
// qualified event, with one-shot halt and a wrapping pulse total.
module pulse_divider
    import pulse_divider_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = DIV_DEFAULT_DEF,
    parameter int EDGE_MODE   = EVT_LEVEL,
    parameter int TOT_W       = TOT_W_DEF
) (
    input logic            clk,
    input logic            rst,
    pulse_divider_if.slave bus
);

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);

    logic             ev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [TOT_W-1:0] tot;
    logic             pulse_r;
    logic             err_r;
    run_state_e       state;

    pulse_divider_evt_qualify #(
        .EDGE_MODE(EDGE_MODE)
    ) u_qualify (
        .clk   (clk),
        .rst   (rst),
        .in_evt(bus.in_evt),
        .ev    (ev)
    );

    // Arm only matters while halted; when already running it falls through
    // so an event in the same cycle is still counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div     <= DIV_INIT;
            tot     <= '0;
            pulse_r <= 1'b0;
            err_r   <= 1'b0;
            state   <= ST_RUN;
        end else begin
            pulse_r <= 1'b0;
            err_r   <= 1'b0;
            if (bus.clear) begin
                cnt   <= '0;
                state <= ST_RUN;
            end else if (bus.div_load) begin
                if (bus.div_value != '0) begin
                    div   <= bus.div_value;
                    cnt   <= '0;
                    state <= ST_RUN;
                end else begin
                    err_r <= 1'b1;
                end
            end else if (bus.arm && state == ST_DONE) begin
                state <= ST_RUN;
            end else if (ev && state == ST_RUN) begin
                if (cnt == div - 1'b1) begin
                    cnt     <= '0;
                    pulse_r <= 1'b1;
                    tot     <= tot + 1'b1;
                    if (bus.oneshot) begin
                        state <= ST_DONE;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out_pulse = pulse_r;
    assign bus.done      = (state == ST_DONE);
    assign bus.count     = cnt;
    assign bus.total     = tot;
    assign bus.cfg_err   = err_r;

endmodule

// File: tb/tb_pulse_divider.sv
// Directed bench for pulse_divider: level, rising-edge and narrow-total
// instances driven one at a time, with a pulse scoreboard.
module tb_pulse_divider;
    import pulse_divider_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pulse_divider_if #(.CNT_W(8), .TOT_W(16)) if_lvl ();
    pulse_divider_if #(.CNT_W(8), .TOT_W(16)) if_rise ();
    pulse_divider_if #(.CNT_W(8), .TOT_W(4))  if_wrap ();

    pulse_divider #(.CNT_W(8), .DIV_DEFAULT(10), .EDGE_MODE(EVT_LEVEL), .TOT_W(16)) u_lvl (
        .clk(clk), .rst(rst), .bus(if_lvl)
    );
    pulse_divider #(.CNT_W(8), .DIV_DEFAULT(10), .EDGE_MODE(EVT_RISE), .TOT_W(16)) u_rise (
        .clk(clk), .rst(rst), .bus(if_rise)
    );
    pulse_divider #(.CNT_W(8), .DIV_DEFAULT(10), .EDGE_MODE(EVT_LEVEL), .TOT_W(4)) u_wrap (
        .clk(clk), .rst(rst), .bus(if_wrap)
    );

    typedef struct {
        int inst;
        int step;
        int total;
    } pulse_t;

    pulse_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    int edge_mode[3] = '{0, 1, 0};
    int tot_mask[3]  = '{65535, 65535, 15};
    int m_cnt[3];
    int m_div[3];
    int m_done[3];
    int m_total[3];
    int m_prev[3];
    int m_err[3];
    int last_pulse_step[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected values come from a behavioural model of the divider contract;
    // pulses go through the scoreboard queue tagged with the step they are due.
    task automatic checkOutput(input int j);
        logic        o_pulse;
        logic [31:0] o_cnt, o_done, o_tot, o_err;
        bit          due;
        case (j)
            0: begin o_pulse = if_lvl.out_pulse;  o_cnt = 32'(if_lvl.count);  o_done = 32'(if_lvl.done);
                     o_tot = 32'(if_lvl.total);  o_err = 32'(if_lvl.cfg_err); end
            1: begin o_pulse = if_rise.out_pulse; o_cnt = 32'(if_rise.count); o_done = 32'(if_rise.done);
                     o_tot = 32'(if_rise.total); o_err = 32'(if_rise.cfg_err); end
            default: begin o_pulse = if_wrap.out_pulse; o_cnt = 32'(if_wrap.count); o_done = 32'(if_wrap.done);
                     o_tot = 32'(if_wrap.total); o_err = 32'(if_wrap.cfg_err); end
        endcase
        chk($sformatf("i%0d_count@%0d", j, step_no), o_cnt, m_cnt[j]);
        chk($sformatf("i%0d_done@%0d", j, step_no), o_done, m_done[j]);
        chk($sformatf("i%0d_cfg_err@%0d", j, step_no), o_err, m_err[j]);
        due = (exp_q.size() > 0) && (exp_q[0].inst == j) && (exp_q[0].step == step_no);
        chk($sformatf("i%0d_out_pulse@%0d", j, step_no), {31'b0, o_pulse}, {31'b0, due});
        if (due) begin
            chk($sformatf("i%0d_total_at_pulse@%0d", j, step_no), o_tot, exp_q[0].total);
            void'(exp_q.pop_front());
        end
        if (o_pulse === 1'b1) last_pulse_step[j] = step_no;
    endtask

    task automatic applyStimulus(input int k, input logic e, input logic c, input logic l,
                                 input logic [7:0] v, input logic os, input logic a);
        logic ej, cj, lj, osj, aj, ev;
        if_lvl.in_evt  = (k == 0) & e; if_lvl.clear  = (k == 0) & c; if_lvl.div_load  = (k == 0) & l;
        if_lvl.div_value  = (k == 0) ? v : 8'd0; if_lvl.oneshot  = (k == 0) & os; if_lvl.arm  = (k == 0) & a;
        if_rise.in_evt = (k == 1) & e; if_rise.clear = (k == 1) & c; if_rise.div_load = (k == 1) & l;
        if_rise.div_value = (k == 1) ? v : 8'd0; if_rise.oneshot = (k == 1) & os; if_rise.arm = (k == 1) & a;
        if_wrap.in_evt = (k == 2) & e; if_wrap.clear = (k == 2) & c; if_wrap.div_load = (k == 2) & l;
        if_wrap.div_value = (k == 2) ? v : 8'd0; if_wrap.oneshot = (k == 2) & os; if_wrap.arm = (k == 2) & a;
        for (int j = 0; j < 3; j++) begin
            ej = (j == k) & e; cj = (j == k) & c; lj = (j == k) & l;
            osj = (j == k) & os; aj = (j == k) & a;
            ev = (edge_mode[j] == 1) ? (ej & (m_prev[j] == 0)) : ej;
            m_prev[j] = int'(ej);
            m_err[j]  = 0;
            if (cj) begin
                m_cnt[j] = 0; m_done[j] = 0;
            end else if (lj) begin
                if (v != 8'd0 && j == k) begin
                    m_div[j] = int'(v); m_cnt[j] = 0; m_done[j] = 0;
                end else begin
                    m_err[j] = 1;
                end
            end else if (aj && m_done[j] == 1) begin
                m_done[j] = 0;
            end else if (ev && m_done[j] == 0) begin
                if (m_cnt[j] == m_div[j] - 1) begin
                    m_cnt[j]   = 0;
                    m_total[j] = (m_total[j] + 1) & tot_mask[j];
                    if (osj) m_done[j] = 1;
                    exp_q.push_back('{j, step_no, m_total[j]});
                end else begin
                    m_cnt[j] = m_cnt[j] + 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 3; j++) checkOutput(j);
        step_no++;
    endtask

    task automatic applyReset(input logic e2);
        rst = 1'b1;
        if_lvl.in_evt = 1'b0;  if_lvl.clear = 1'b0;  if_lvl.div_load = 1'b0;  if_lvl.div_value = 8'd0;
        if_lvl.oneshot = 1'b0; if_lvl.arm = 1'b0;
        if_rise.in_evt = 1'b0; if_rise.clear = 1'b0; if_rise.div_load = 1'b0; if_rise.div_value = 8'd0;
        if_rise.oneshot = 1'b0; if_rise.arm = 1'b0;
        if_wrap.in_evt = e2;   if_wrap.clear = 1'b0; if_wrap.div_load = 1'b0; if_wrap.div_value = 8'd0;
        if_wrap.oneshot = 1'b0; if_wrap.arm = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            m_cnt[j] = 0; m_div[j] = 10; m_done[j] = 0; m_total[j] = 0; m_prev[j] = 0; m_err[j] = 0;
        end
        exp_q.delete();
        chk("rst_out_pulse", {31'b0, if_wrap.out_pulse}, 0);
        chk("rst_count", 32'(if_wrap.count), 0);
        chk("rst_total", 32'(if_wrap.total), 0);
        chk("rst_done", {31'b0, if_wrap.done}, 0);
        chk("rst_cfg_err", {31'b0, if_wrap.cfg_err}, 0);
        chk("rst_lvl_total", 32'(if_lvl.total), 0);
        step_no++;
    endtask

    initial begin
        int t0;
        $display("[TB] start");
        applyReset(1'b0);

        // Level input, default divisor of ten.
        t0 = step_no;
        for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
        chk("A_total", 32'(if_lvl.total), 3);
        chk("A_last_pulse_offset", 32'(last_pulse_step[0] - t0), 29);
        chk("A_count", 32'(if_lvl.count), 0);

        // Reload mid-count, then a rejected zero divisor.
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
        chk("B_count7", 32'(if_lvl.count), 7);
        applyStimulus(0, 1, 0, 1, 8'd3, 0, 0);
        chk("B_load_zeroes_cnt", 32'(if_lvl.count), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
        chk("B_total_div3", 32'(if_lvl.total), 4);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
        applyStimulus(0, 1, 0, 1, 8'd0, 0, 0);
        chk("B_cfg_err", {31'b0, if_lvl.cfg_err}, 1);
        chk("B_cnt_kept", 32'(if_lvl.count), 1);
        applyStimulus(0, 0, 0, 0, 8'd0, 0, 0);
        chk("B_cfg_err_once", {31'b0, if_lvl.cfg_err}, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
        chk("B_div_still3", 32'(if_lvl.total), 5);

        // Divide by one: back-to-back pulses.
        applyStimulus(0, 0, 0, 1, 8'd1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
            chk("C_pulse_each", {31'b0, if_lvl.out_pulse}, 1);
        end
        applyStimulus(0, 0, 0, 0, 8'd0, 0, 0);
        chk("C_pulse_stops", {31'b0, if_lvl.out_pulse}, 0);
        chk("C_total", 32'(if_lvl.total), 10);

        // Rising-edge instance, divide by two.
        applyStimulus(1, 0, 0, 1, 8'd2, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0, 8'd0, 0, 0);
        chk("D_hold_one_edge", 32'(if_rise.count), 1);
        chk("D_hold_no_pulse", 32'(if_rise.total), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 8'd0, 0, 0);
            applyStimulus(1, 1, 0, 0, 8'd0, 0, 0);
        end
        chk("D_total", 32'(if_rise.total), 2);
        chk("D_count", 32'(if_rise.count), 1);
        applyStimulus(1, 1, 1, 0, 8'd0, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 1, 0, 0, 8'd0, 0, 0);
        chk("D_clear_no_edge", 32'(if_rise.count), 0);
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 0);
        applyStimulus(1, 1, 0, 0, 8'd0, 0, 0);
        chk("D_new_edge", 32'(if_rise.count), 1);

        // One-shot with divide by four, then re-arm.
        applyStimulus(0, 0, 1, 0, 8'd0, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'd4, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 8'd0, 1, 0);
        chk("E_done", {31'b0, if_lvl.done}, 1);
        chk("E_total_one", 32'(if_lvl.total), 11);
        chk("E_count_halt", 32'(if_lvl.count), 0);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
        chk("E_done_sticky", {31'b0, if_lvl.done}, 1);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 1);
        chk("E_arm_done", {31'b0, if_lvl.done}, 0);
        chk("E_arm_ev_dropped", 32'(if_lvl.count), 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
        chk("E_resume_total", 32'(if_lvl.total), 12);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 1);
        chk("E_arm_running_counts", 32'(if_lvl.count), 1);

        // Narrow total: priority of clear, wrap, reset mid-count.
        for (int i = 0; i < 3; i++) applyStimulus(2, 1, 0, 0, 8'd0, 0, 0);
        applyStimulus(2, 1, 1, 1, 8'd5, 0, 0);
        chk("F_clear_wins_cnt", 32'(if_wrap.count), 0);
        chk("F_clear_wins_err", {31'b0, if_wrap.cfg_err}, 0);
        for (int i = 0; i < 9; i++) applyStimulus(2, 1, 0, 0, 8'd0, 0, 0);
        chk("F_div_unchanged", 32'(if_wrap.count), 9);
        applyStimulus(2, 1, 0, 0, 8'd0, 0, 0);
        chk("F_first_pulse_total", 32'(if_wrap.total), 1);
        applyStimulus(2, 0, 0, 1, 8'd1, 0, 0);
        for (int i = 0; i < 16; i++) applyStimulus(2, 1, 0, 0, 8'd0, 0, 0);
        chk("F_total_wrap", 32'(if_wrap.total), 1);
        applyStimulus(2, 0, 0, 1, 8'd5, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(2, 1, 0, 0, 8'd0, 0, 0);
        chk("F_pre_reset_cnt", 32'(if_wrap.count), 3);
        applyReset(1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(2, 1, 0, 0, 8'd0, 0, 0);
        chk("F_div_default_restored", 32'(if_wrap.total), 1);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
